pin_gen: RTL

Programmable pulse generator: the transmit-side counterpart of `pin_capt`. It replays a queue of (start, width) pulse descriptors onto a pin with quarter-cycle resolution. It runs on `clk300` and emits a 4-bit phase word per cycle to a downstream 4:1 serializer, giving a 0.833 ns tick, the same resolution `pin_capt` resolves with `clk600`/`clk600_90`.

---
 rtl/pin_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pin_gen.sv
// rtl/pin_gen.sv - descriptor-driven pulse generator emitting a 4-tick phase word per clk300 cycle
// Replays queued (start, width) descriptors against a saturating timebase, one active pulse at a time.
module pin_gen #(
  parameter int unsigned TW    = 16,
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk300,
  input  logic          rst_n,
  input  logic          start,
  input  logic          desc_valid,
  output logic          desc_ready,
  input  logic [TW-1:0] desc_start,
  input  logic [DW-1:0] desc_width,
  output logic [3:0]    pin_word,
  output logic          err_late,
  output logic          idle
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = TW - 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [TW-1:0] fs_q [DEPTH];
  logic [DW-1:0] fw_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic          running_q, running_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          active_q, active_d;
  logic [TW-1:0] a_start_q, a_start_d;
  logic [TW:0]   a_end_q, a_end_d;
  logic [3:0]    pin_word_q, pin_word_d;
  logic          err_late_q, err_late_d;
  logic          idle_q, idle_d;

  logic          push, pop, nonempty;
  logic [TW-1:0] head_start;
  logic [DW-1:0] head_width;
  logic [TW:0]   last_cyc;
  logic          finishing;
  logic [CW:0]   target;
  logic          head_late, head_zero;
  logic [3:0]    pat;

  assign desc_ready = (cnt_q != FULL_CNT);
  assign nonempty   = (cnt_q != '0);
  assign push       = desc_valid && desc_ready;
  assign head_start = fs_q[rp_q];
  assign head_width = fw_q[rp_q];

  assign last_cyc  = (a_end_q - (TW+1)'(1)) >> 2;
  assign finishing = active_q && ({3'b000, cyc_q} == last_cyc);

  // Target is one bit wider than cyc so a saturated timebase cannot wrap and accept stale entries.
  assign target    = start ? '0 : ({1'b0, cyc_q} + (CW+1)'(1));
  assign head_late = ({1'b0, head_start[TW-1:2]} < target);
  assign head_zero = (head_width == '0);
  assign pop       = (start || running_q) && (!active_q || finishing || start) && nonempty;

  for (genvar k = 0; k < 4; k++) begin : g_tick
    logic [TW:0] tick;
    assign tick   = {1'b0, cyc_q, 2'(k)};
    assign pat[k] = active_q && ({1'b0, a_start_q} <= tick) && (tick < a_end_q);
  end

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    running_d  = running_q;
    cyc_d      = cyc_q;
    active_d   = active_q;
    a_start_d  = a_start_q;
    a_end_d    = a_end_q;
    err_late_d = err_late_q;
    pin_word_d = pat;

    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    if (start) begin
      running_d = 1'b1;
      cyc_d     = '0;
    end else if (running_q && (cyc_q != '1)) begin
      cyc_d = cyc_q + CW'(1);
    end

    if (start || finishing) active_d = 1'b0;
    if (start) err_late_d = 1'b0;

    if (pop && !head_zero) begin
      if (head_late) begin
        err_late_d = 1'b1;
      end else begin
        active_d  = 1'b1;
        a_start_d = head_start;
        a_end_d   = {1'b0, head_start} + (TW+1)'(head_width);
      end
    end

    idle_d = (cnt_d == '0) && !active_d;
  end

  // Storage is left unreset; pointers and count define validity.
  always_ff @(posedge clk300) begin
    if (push) begin
      fs_q[wp_q] <= desc_start;
      fw_q[wp_q] <= desc_width;
    end
  end

  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      running_q  <= 1'b0;
      cyc_q      <= '0;
      active_q   <= 1'b0;
      a_start_q  <= '0;
      a_end_q    <= '0;
      pin_word_q <= '0;
      err_late_q <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      running_q  <= running_d;
      cyc_q      <= cyc_d;
      active_q   <= active_d;
      a_start_q  <= a_start_d;
      a_end_q    <= a_end_d;
      pin_word_q <= pin_word_d;
      err_late_q <= err_late_d;
      idle_q     <= idle_d;
    end
  end

  assign pin_word = pin_word_q;
  assign err_late = err_late_q;
  assign idle     = idle_q;

endmodule
